// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 transaction controller: accepts a word and bit length, drives the
// clk_div start/n_pulses pair, shifts MOSI out MSB-first and captures MISO.
module spi_xfer_ctrl #(
  parameter int  SPI_MAXLEN = 16,
  localparam int LW         = $clog2(SPI_MAXLEN) + 1,
  localparam int NW         = LW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [SPI_MAXLEN-1:0] tx_data,
  input  logic [LW-1:0]         tx_len,
  output logic                  rx_valid,
  output logic [SPI_MAXLEN-1:0] rx_data,
  output logic                  busy,
  output logic                  start,
  output logic [NW-1:0]         n_pulses,
  input  logic                  spi_clk,
  output logic                  cs_n,
  output logic                  mosi,
  input  logic                  miso
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_e;

  state_e                state_q;
  logic [SPI_MAXLEN-1:0] tx_sr_q;
  logic [SPI_MAXLEN-1:0] rx_sr_q;
  logic [SPI_MAXLEN-1:0] rx_data_q;
  logic [LW-1:0]         len_q;
  logic [LW-1:0]         cnt_q;
  logic [NW-1:0]         n_pulses_q;
  logic                  spi_clk_q;
  logic                  start_q;
  logic                  cs_n_q;
  logic                  mosi_q;
  logic                  rx_valid_q;

  logic [LW-1:0]         len_in;
  logic [LW-1:0]         cnt_nxt;
  logic [SPI_MAXLEN-1:0] tx_aligned;
  logic                  rise;
  logic                  fall;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    len_in     = (tx_len > LW'(SPI_MAXLEN)) ? LW'(SPI_MAXLEN) : tx_len;
    tx_aligned = tx_data << (LW'(SPI_MAXLEN) - len_in);
    cnt_nxt    = cnt_q + LW'(1);
    rise       = spi_clk & ~spi_clk_q;
    fall       = ~spi_clk & spi_clk_q;
  end

  // The word is stored MSB-aligned so the next bit to send is always at the top.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      n_pulses_q <= '0;
      spi_clk_q  <= 1'b0;
      start_q    <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      spi_clk_q  <= spi_clk;
      rx_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_valid) begin
            rx_sr_q    <= '0;
            cnt_q      <= '0;
            len_q      <= len_in;
            n_pulses_q <= {len_in, 1'b0};
            if (len_in == '0) begin
              rx_valid_q <= 1'b1;
              rx_data_q  <= '0;
              state_q    <= DONE;
            end else begin
              cs_n_q  <= 1'b0;
              mosi_q  <= tx_aligned[SPI_MAXLEN-1];
              tx_sr_q <= tx_aligned << 1;
              state_q <= SETUP;
            end
          end
        end
        SETUP: begin
          start_q <= 1'b1;
          state_q <= SHIFT;
        end
        SHIFT: begin
          if (rise) begin
            rx_sr_q <= {rx_sr_q[SPI_MAXLEN-2:0], miso};
          end else if (fall) begin
            cnt_q <= cnt_nxt;
            // Dropping start on the last fall keeps clk_div from adding a toggle.
            if (cnt_nxt == len_q) begin
              start_q <= 1'b0;
              state_q <= HOLD;
            end else begin
              mosi_q  <= tx_sr_q[SPI_MAXLEN-1];
              tx_sr_q <= tx_sr_q << 1;
            end
          end
        end
        HOLD: begin
          cs_n_q     <= 1'b1;
          mosi_q     <= 1'b0;
          rx_valid_q <= 1'b1;
          rx_data_q  <= rx_sr_q;
          state_q    <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign start    = start_q;
  assign n_pulses = n_pulses_q;
  assign cs_n     = cs_n_q;
  assign mosi     = mosi_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: behavioural clk_div, MISO source and a
// per-transfer reference computed from length, data and MISO pattern.
module tb_spi_xfer_ctrl;

  localparam int MAXLEN = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [15:0] tx_data = '0;
  logic [4:0]  tx_len = '0;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        busy;
  logic        start;
  logic [5:0]  n_pulses;
  logic        spi_clk;
  logic        cs_n;
  logic        mosi;
  logic        miso;

  int n_checks = 0;
  int n_fail   = 0;

  // Environment state: clk_div model, MISO source, edge monitors.
  logic [5:0]  div_cnt;
  int          miso_mode = 0;          // 0: pattern, 1: loopback
  logic [15:0] miso_pat  = '0;         // bit i is the i-th bit presented
  int          fall_base = 0;
  int          miso_idx;
  int          rise_total   = 0;
  int          fall_total   = 0;
  int          toggle_total = 0;
  int          start_total  = 0;
  logic        mosi_log [0:2047];

  spi_xfer_ctrl #(.SPI_MAXLEN(MAXLEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_len   (tx_len),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .busy     (busy),
    .start    (start),
    .n_pulses (n_pulses),
    .spi_clk  (spi_clk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      spi_clk <= 1'b0;
      div_cnt <= '0;
    end else if (!start) begin
      spi_clk <= 1'b0;
      div_cnt <= n_pulses;
    end else if (div_cnt != '0) begin
      spi_clk <= ~spi_clk;
      div_cnt <= div_cnt - 6'd1;
    end
  end

  assign miso_idx = fall_total - fall_base;
  assign miso = (miso_mode == 1) ? mosi :
                ((miso_idx >= 0 && miso_idx < 16) ? miso_pat[miso_idx[3:0]] : 1'b0);

  always @(posedge spi_clk) begin
    mosi_log[rise_total[10:0]] <= mosi;
    rise_total <= rise_total + 1;
  end
  always @(negedge spi_clk) fall_total <= fall_total + 1;
  always @(spi_clk)         toggle_total <= toggle_total + 1;
  always @(negedge clk)     if (start) start_total <= start_total + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transfer: expectations come from len/data/pattern, timing from the latency rules.
  task automatic run_xfer(input logic [15:0] data, input int len_req, input int mode,
                          input logic [15:0] pat, input bit keep_valid);
    int          len, exp_cyc, got_cyc, waited, ready_hi, rb, tb, sb;
    logic [15:0] exp_rx, exp_mosi, got_mosi;
    len      = (len_req > MAXLEN) ? MAXLEN : len_req;
    exp_rx   = '0;
    exp_mosi = '0;
    for (int i = 0; i < len; i++) begin
      exp_mosi[len-1-i] = data[len-1-i];
      exp_rx[len-1-i]   = (mode == 1) ? data[len-1-i] : pat[i];
    end
    exp_cyc = (len == 0) ? 1 : 4 + 2 * len;

    waited = 0;
    while (!tx_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_accept", 32'(tx_ready), 32'd1);
    miso_mode = mode;
    miso_pat  = pat;
    fall_base = fall_total;
    rb = rise_total;
    tb = toggle_total;
    sb = start_total;
    tx_valid = 1'b1;
    tx_data  = data;
    tx_len   = 5'(len_req);
    @(posedge clk);

    got_cyc  = -1;
    ready_hi = 0;
    for (int c = 1; c <= 60 && got_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("setup_n_pulses", 32'(n_pulses), 32'(2 * len));
        check("setup_cs_n", 32'(cs_n), 32'(len == 0));
        if (!keep_valid) begin
          tx_valid = 1'b0;
          tx_data  = 16'($urandom);
          tx_len   = 5'($urandom);
        end
      end
      if (tx_ready) ready_hi++;
      if (rx_valid) begin
        got_cyc = c;
        check("rx_data", 32'(rx_data), 32'(exp_rx));
        check("done_cs_n", 32'(cs_n), 32'd1);
        check("done_n_pulses", 32'(n_pulses), 32'(2 * len));
      end
    end
    check("rx_valid_cycle", 32'(got_cyc), 32'(exp_cyc));
    check("ready_while_busy", 32'(ready_hi), 32'd0);

    @(negedge clk);
    check("after_ready", 32'(tx_ready), 32'd1);
    check("after_busy", 32'(busy), 32'd0);
    check("after_rx_valid", 32'(rx_valid), 32'd0);
    check("after_rx_hold", 32'(rx_data), 32'(exp_rx));
    check("rise_count", 32'(rise_total - rb), 32'(len));
    check("toggle_count", 32'(toggle_total - tb), 32'(2 * len));
    check("start_cycles", 32'(start_total - sb), 32'((len == 0) ? 0 : 2 * len + 1));
    got_mosi = '0;
    for (int i = 0; i < len; i++) got_mosi[len-1-i] = mosi_log[rb+i];
    check("mosi_bits", 32'(got_mosi), 32'(exp_mosi));
  endtask

  initial begin
    int rb, w;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    repeat (5) @(negedge clk);
    check("idle_cs_n", 32'(cs_n), 32'd1);
    check("idle_start", 32'(start), 32'd0);
    check("idle_tx_ready", 32'(tx_ready), 32'd1);
    check("idle_rx_valid", 32'(rx_valid), 32'd0);
    check("idle_mosi", 32'(mosi), 32'd0);
    check("idle_n_pulses", 32'(n_pulses), 32'd0);
    check("idle_rx_data", 32'(rx_data), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    run_xfer(16'h00A5, 8, 1, 16'h0000, 1'b0);
    run_xfer(16'hFFFF, 16, 0, 16'h0000, 1'b0);
    run_xfer(16'h1234, 0, 0, 16'hFFFF, 1'b0);
    run_xfer(16'hC3A5, 20, 1, 16'h0000, 1'b0);

    // Abort a 12-bit transfer after its third rising spi_clk edge.
    @(negedge clk);
    miso_mode = 0;
    miso_pat  = 16'hFFFF;
    fall_base = fall_total;
    rb = rise_total;
    tx_valid = 1'b1;
    tx_data  = 16'h0ABC;
    tx_len   = 5'd12;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    w = 0;
    while ((rise_total - rb) < 3 && w < 60) begin
      @(negedge clk);
      w++;
    end
    check("abort_three_rises", 32'(rise_total - rb), 32'd3);
    #1 rst = 1'b0;
    #1;
    check("abort_cs_n", 32'(cs_n), 32'd1);
    check("abort_start", 32'(start), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rx_data", 32'(rx_data), 32'd0);
    check("abort_mosi", 32'(mosi), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // tx_valid held across the first transfer: the repeat is taken only after rx_valid.
    run_xfer(16'h05A3, 12, 1, 16'h0000, 1'b1);
    run_xfer(16'h05A3, 12, 1, 16'h0000, 1'b0);

    for (int k = 0; k < 12; k++) begin
      run_xfer(16'($urandom), int'($urandom_range(0, 20)), int'($urandom_range(0, 1)),
               16'($urandom), 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
